// File: rtl/exec_ctrl_pkg.sv
// Shared types for the execution controller: FSM state encoding.
package exec_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/exec_ctrl_step_debouncer.sv
// Step-button conditioner: synchronizer, optional stability filter
// (EXEC_CTRL_DEBOUNCE_EN) and rising-edge detector producing a 1-cycle pulse.
module step_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic step_async,
  output logic step_pulse
);

`ifdef EXEC_CTRL_DEBOUNCE_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   level_p1;
  logic                   level_dly_p2;

  // Stage 0: metastability synchronizer
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0[0] <= step_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p0[i] <= sync_p0[i-1];
      end
    end
  end

  // Stage 1: level accepted only after DEBOUNCE_CYCLES consecutive differing samples
  if (FILTER_EN && DEBOUNCE_CYCLES > 0) begin : g_filter
    localparam int unsigned SW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_CYCLES - 1);

    logic [SW-1:0] stable_cnt;
    logic          filt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        stable_cnt <= '0;
        filt       <= 1'b0;
      end else if (sync_p0[SYNC_STAGES-1] == filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        filt       <= sync_p0[SYNC_STAGES-1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + SW'(1);
      end
    end

    assign level_p1 = filt;
  end else begin : g_direct
    assign level_p1 = sync_p0[SYNC_STAGES-1];
  end

  // Stage 2: rising-edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_dly_p2 <= 1'b0;
    end else begin
      level_dly_p2 <= level_p1;
    end
  end

  assign step_pulse = level_p1 & ~level_dly_p2;

endmodule

// File: rtl/exec_ctrl.sv
// Processor clock-enable controller: run / single-step / halt with cycle limit.
// Optional step debounce filter is compiled in by defining EXEC_CTRL_DEBOUNCE_EN.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_select,
  input  logic               clk_step,
  input  logic               halt_req,
  input  logic [CNT_W-1:0]   cycle_limit,
  output logic               cpu_en,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               halted
);

  state_t           state_q;
  state_t           state_nxt;
  logic             cpu_en_nxt;
  logic [CNT_W-1:0] count_q;
  logic             step_pulse;
  logic             limit_hit;
  logic             stop_req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  step_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk       (clk),
    .rst       (rst),
    .step_async(clk_step),
    .step_pulse(step_pulse)
  );

  // count_q already includes the current enabled cycle, so reaching the limit stops the next one
  assign limit_hit = (cycle_limit != '0) && (count_q >= cycle_limit);
  assign stop_req  = halt_req || limit_hit;

  always_comb begin
    state_nxt  = state_q;
    cpu_en_nxt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clk_select) begin
          state_nxt = ST_STEP;
        end else begin
          state_nxt  = ST_RUN;
          cpu_en_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          state_nxt = ST_HALT;
        end else if (clk_select) begin
          state_nxt = ST_STEP;
        end else begin
          cpu_en_nxt = 1'b1;
        end
      end
      ST_STEP: begin
        if (stop_req) begin
          state_nxt = ST_HALT;
        end else if (!clk_select) begin
          state_nxt  = ST_RUN;
          cpu_en_nxt = 1'b1;
        end else begin
          cpu_en_nxt = step_pulse;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cpu_en  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      cpu_en  <= cpu_en_nxt;
      if (cpu_en_nxt) begin
        count_q <= sat_inc(count_q);
      end
    end
  end

  assign state       = state_q;
  assign cycle_count = count_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed self-checking bench for exec_ctrl.
module tb_exec_ctrl;

`ifdef EXEC_CTRL_DEBOUNCE_EN
  localparam int LAT        = 2 + 4 + 1;
  localparam int GLITCH_EXP = 0;
`else
  localparam int LAT        = 2 + 1;
  localparam int GLITCH_EXP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_select;
  logic        clk_step;
  logic        halt_req;
  logic [31:0] cycle_limit;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        halted;

  int errors = 0;
  int checks = 0;

  exec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clk_select (clk_select),
    .clk_step   (clk_step),
    .halt_req   (halt_req),
    .cycle_limit(cycle_limit),
    .cpu_en     (cpu_en),
    .state      (state),
    .cycle_count(cycle_count),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int at;

    // Reset state
    rst = 1'b0; clk_select = 1'b0; clk_step = 1'b0; halt_req = 1'b0;
    cycle_limit = 32'd10;
    tick(); tick();
    check("rst_state", state, 2'd0);
    check("rst_cpu_en", cpu_en, 1'b0);
    check("rst_count", cycle_count, 32'd0);
    check("rst_halted", halted, 1'b0);

    // Continuous run with cycle_limit=10
    rst = 1'b1;
    tick();
    check("run_first_state", state, 2'd1);
    check("run_first_en", cpu_en, 1'b1);
    check("run_first_count", cycle_count, 32'd1);
    n = 1;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (cpu_en) n++;
    end
    check("limit_en_cycles", n, 10);
    check("limit_count", cycle_count, 32'd10);
    check("limit_halted", halted, 1'b1);
    check("limit_state", state, 2'd3);
    clk_select = 1'b1; clk_step = 1'b1;
    tick(); tick(); tick(); tick();
    check("halt_absorb_state", state, 2'd3);
    check("halt_absorb_count", cycle_count, 32'd10);
    check("halt_absorb_en", cpu_en, 1'b0);
    clk_step = 1'b0;

    // Single-step mode: three clean pulses of 8 cycles
    cycle_limit = 32'd0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("step_enter_state", state, 2'd2);
    check("step_enter_en", cpu_en, 1'b0);
    for (int p = 0; p < 3; p++) begin
      n = 0; at = -1;
      clk_step = 1'b1;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (t == 8) clk_step = 1'b0;
        if (cpu_en) begin
          n++;
          at = t;
        end
      end
      check("step_pulse_count", n, 1);
      check("step_pulse_latency", at, LAT);
    end
    check("step_total_count", cycle_count, 32'd3);

    // Short glitch on clk_step
    n = 0;
    clk_step = 1'b1;
    tick(); tick();
    clk_step = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (cpu_en) n++;
    end
    check("glitch_pulses", n, GLITCH_EXP);
    check("glitch_count", cycle_count, 32'(3 + GLITCH_EXP));

    // Edge seen while in RUN is discarded, not replayed on entering STEP
    clk_select = 1'b0;
    tick();
    check("back_to_run_state", state, 2'd1);
    check("back_to_run_en", cpu_en, 1'b1);
    clk_step = 1'b1;
    for (int t = 0; t < 12; t++) tick();
    clk_select = 1'b1;
    tick();
    check("run_to_step_state", state, 2'd2);
    check("run_to_step_en", cpu_en, 1'b0);
    n = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (cpu_en) n++;
    end
    check("discarded_edge_pulses", n, 0);
    clk_step = 1'b0;

    // halt_req wins over simultaneous clk_select change
    clk_select = 1'b0;
    tick();
    check("pre_halt_state", state, 2'd1);
    halt_req = 1'b1; clk_select = 1'b1;
    tick();
    check("halt_pri_state", state, 2'd3);
    check("halt_pri_en", cpu_en, 1'b0);
    check("halt_pri_halted", halted, 1'b1);
    halt_req = 1'b0;
    tick();
    check("halt_pri_hold", state, 2'd3);

    // Reset mid-RUN at cycle_count=5
    clk_select = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    check("midrun_count5", cycle_count, 32'd5);
    check("midrun_en", cpu_en, 1'b1);
    rst = 1'b0;
    tick();
    check("midrst_en", cpu_en, 1'b0);
    check("midrst_count", cycle_count, 32'd0);
    check("midrst_state", state, 2'd0);
    check("midrst_halted", halted, 1'b0);
    rst = 1'b1;
    tick();
    check("resume_state", state, 2'd1);
    check("resume_count", cycle_count, 32'd1);
    check("resume_en", cpu_en, 1'b1);

    // Limit lowered below current count halts on the next cycle
    for (int t = 0; t < 5; t++) tick();
    check("prelimit_count", cycle_count, 32'd6);
    cycle_limit = 32'd3;
    tick();
    check("lowlimit_state", state, 2'd3);
    check("lowlimit_en", cpu_en, 1'b0);
    check("lowlimit_count", cycle_count, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
